// File: rtl/osd_mam_mem_pkg.sv
// Shared types for the osd_mam memory responder.
//   state_e : responder state (IDLE / WRITE / READ)
//   BEAT_W  : width of the per-burst beat counter and of req_size
package osd_mam_mem_pkg;
  localparam int BEAT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_e;
endpackage

// File: rtl/osd_mam_mem_responder_if.sv
// osd_mam system memory bus: request, write and read channels.
//   master : osd_mam side (drives requests and write beats, accepts reads)
//   slave  : memory side (accepts requests and write beats, drives reads)
interface osd_mam_mem_responder_if
  import osd_mam_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_rw;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic                    req_burst;
  logic [BEAT_W-1:0]       req_size;
  logic                    write_valid;
  logic [DATA_WIDTH-1:0]   write_data;
  logic [DATA_WIDTH/8-1:0] write_strb;
  logic                    write_ready;
  logic                    read_valid;
  logic [DATA_WIDTH-1:0]   read_data;
  logic                    read_ready;

  modport master (
    output req_valid, req_rw, req_addr, req_burst, req_size,
    output write_valid, write_data, write_strb, read_ready,
    input  req_ready, write_ready, read_valid, read_data
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_burst, req_size,
    input  write_valid, write_data, write_strb, read_ready,
    output req_ready, write_ready, read_valid, read_data
  );
endinterface

// File: rtl/osd_mam_mem_array.sv
// Single-port, byte-enabled RAM with a registered read port.
//   clk   : clock
//   addr  : word address
//   re    : read enable, rdata updates on the next edge and holds otherwise
//   we    : write enable, bytes selected by wstrb are written
//   wdata : write data
//   wstrb : byte enables, bit i covers byte i
//   rdata : registered read data
module osd_mam_mem_array #(
  parameter int DATA_WIDTH = 512,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                         clk,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic                         re,
  input  logic                         we,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  output logic [DATA_WIDTH-1:0]        rdata
);
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (wstrb[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/osd_mam_mem_responder.sv
// Memory-side responder for the osd_mam memory bus, backed by an internal
// byte-enabled word array. Serves single-word and burst reads/writes.
//   clk : clock
//   rst : synchronous active-high reset (memory contents are kept)
//   bus : osd_mam memory bus, slave side
module osd_mam_mem_responder
  import osd_mam_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input logic                 clk,
  input logic                 rst,
  osd_mam_mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int OFF_W = $clog2(DATA_WIDTH / 8);
  localparam logic [IDX_W-1:0]  IDX_ONE = IDX_W'(1);
  localparam logic [BEAT_W-1:0] CNT_ONE = BEAT_W'(1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BEAT_W-1:0]   cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                write_ready_q, write_ready_d;
  logic                read_valid_q, read_valid_d;

  logic [IDX_W-1:0]      req_idx;
  logic [BEAT_W-1:0]     req_cnt;
  logic                  req_fire, wr_fire, rd_fire;
  logic [IDX_W-1:0]      ram_addr;
  logic                  ram_re, ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  unused_addr;

  // Outputs are forced low for the whole reset cycle, not just after the edge.
  assign bus.req_ready   = req_ready_q & ~rst;
  assign bus.write_ready = write_ready_q & ~rst;
  assign bus.read_valid  = read_valid_q & ~rst;
  assign bus.read_data   = bus.read_valid ? ram_rdata : '0;

  assign req_fire = bus.req_valid & bus.req_ready;
  assign wr_fire  = bus.write_valid & bus.write_ready;
  assign rd_fire  = bus.read_valid & bus.read_ready;

  // Byte-offset bits and address bits above the array depth are dropped.
  assign req_idx     = bus.req_addr[OFF_W +: IDX_W];
  assign req_cnt     = (bus.req_burst && bus.req_size != '0) ? bus.req_size : CNT_ONE;
  assign unused_addr = ^bus.req_addr;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    req_ready_d   = req_ready_q;
    write_ready_d = write_ready_q;
    read_valid_d  = read_valid_q;
    ram_addr      = idx_q;
    ram_re        = 1'b0;
    ram_we        = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The first read word is fetched on the accepting edge so it is
        // presented the very next cycle.
        ram_addr = req_idx;
        if (req_fire) begin
          idx_d       = req_idx;
          cnt_d       = req_cnt;
          req_ready_d = 1'b0;
          if (bus.req_rw) begin
            state_d       = WRITE;
            write_ready_d = 1'b1;
          end else begin
            state_d      = READ;
            read_valid_d = 1'b1;
            ram_re       = 1'b1;
          end
        end
      end
      WRITE: begin
        ram_we = wr_fire;
        if (wr_fire) begin
          idx_d = idx_q + IDX_ONE;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d       = IDLE;
            write_ready_d = 1'b0;
            req_ready_d   = 1'b1;
          end
        end
      end
      READ: begin
        // The next word is prefetched on the handshake edge, so beats stream
        // back to back; without a handshake the RAM output simply holds.
        if (rd_fire) begin
          if (cnt_q == CNT_ONE) begin
            state_d      = IDLE;
            read_valid_d = 1'b0;
            req_ready_d  = 1'b1;
          end else begin
            idx_d    = idx_q + IDX_ONE;
            cnt_d    = cnt_q - CNT_ONE;
            ram_addr = idx_q + IDX_ONE;
            ram_re   = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      write_ready_q <= 1'b0;
      read_valid_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      write_ready_q <= write_ready_d;
      read_valid_q  <= read_valid_d;
    end
    idx_q <= idx_d;
    cnt_q <= cnt_d;
  end

  osd_mam_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_array (
    .clk   (clk),
    .addr  (ram_addr),
    .re    (ram_re),
    .we    (ram_we),
    .wdata (bus.write_data),
    .wstrb (bus.write_strb),
    .rdata (ram_rdata)
  );
endmodule

// File: tb/tb_osd_mam_mem_responder.sv
// Scoreboard bench for osd_mam_mem_responder: stimulus pushes expected read
// words from a flat memory model; a monitor pops them on every read handshake.
module tb_osd_mam_mem_responder;
  localparam int DW = 512;
  localparam int AW = 32;
  localparam int MW = 1024;
  localparam int NB = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  osd_mam_mem_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  osd_mam_mem_responder #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_WORDS  (MW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_m [MW];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] wd_q  [$];
  logic [NB-1:0] ws_q  [$];
  bit            rr_auto   = 1'b0;
  logic          rr_manual = 1'b0;

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(string nm, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  function automatic int beats(bit burst, int size);
    return (burst && size != 0) ? size : 1;
  endfunction

  function automatic int word_of(logic [AW-1:0] a);
    return int'(a / NB) % MW;
  endfunction

  function automatic void model_write(int w, logic [DW-1:0] d, logic [NB-1:0] s);
    for (int b = 0; b < NB; b++) if (s[b]) mem_m[w][b*8 +: 8] = d[b*8 +: 8];
  endfunction

  // Single driver of read_ready; runs after stimulus updates rr_manual.
  always @(posedge clk) begin
    #2;
    bus.read_ready = rr_auto ? ($urandom_range(0, 3) != 0) : rr_manual;
  end

  // Scoreboard monitor: a handshake completes on the following rising edge.
  always @(negedge clk) begin
    if (bus.read_valid === 1'b1 && bus.read_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_extra_beat act=%h exp=none", bus.read_data);
      end else begin
        chk("rd_beat", bus.read_data, exp_q.pop_front());
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send_req(bit rw, logic [AW-1:0] addr, bit burst, logic [15:0] size);
    int t = 0;
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_addr  = addr;
    bus.req_burst = burst;
    bus.req_size  = size;
    do begin
      @(negedge clk);
      t++;
    end while (bus.req_ready !== 1'b1 && t < 50);
    if (bus.req_ready !== 1'b1) begin
      $display("FAIL req_timeout act=%b exp=1", bus.req_ready);
      $fatal(1, "request not accepted");
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom();
    bus.req_size  = 16'($urandom());
  endtask

  task automatic do_write(logic [AW-1:0] addr, bit burst, int size, bit gaps);
    int n = beats(burst, size);
    int w = word_of(addr);
    send_req(1'b1, addr, burst, 16'(size));
    for (int b = 0; b < n; b++) begin
      logic [DW-1:0] d;
      logic [NB-1:0] s;
      int t = 0;
      int g = gaps ? $urandom_range(0, 2) : 0;
      d = (wd_q.size() != 0) ? wd_q.pop_front() : rnd_word();
      s = (ws_q.size() != 0) ? ws_q.pop_front() : '1;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
      bus.write_valid = 1'b1;
      bus.write_data  = d;
      bus.write_strb  = s;
      do begin
        @(negedge clk);
        t++;
      end while (bus.write_ready !== 1'b1 && t < 50);
      if (bus.write_ready !== 1'b1) begin
        $display("FAIL wr_timeout act=%b exp=1", bus.write_ready);
        $fatal(1, "write beat not accepted");
      end
      @(posedge clk);
      #1;
      model_write(w, d, s);
      w = (w + 1) % MW;
      bus.write_valid = 1'b0;
      bus.write_data  = rnd_word();
    end
    @(negedge clk);
    chk1("wr_done_wready", bus.write_ready, 1'b0);
    chk1("wr_done_rqready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_read(logic [AW-1:0] addr, bit burst, int size);
    int n = beats(burst, size);
    int w = word_of(addr);
    int t = 0;
    for (int i = 0; i < n; i++) exp_q.push_back(mem_m[(w + i) % MW]);
    send_req(1'b0, addr, burst, 16'(size));
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL rd_timeout act=%0d exp=0", exp_q.size());
      $fatal(1, "read beats missing");
    end
    @(negedge clk);
    chk1("rd_done_rvalid", bus.read_valid, 1'b0);
    chk1("rd_done_rqready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rvalid();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus.read_valid !== 1'b1 && t < 50);
    if (bus.read_valid !== 1'b1) begin
      $display("FAIL rvalid_timeout act=%b exp=1", bus.read_valid);
      $fatal(1, "read beat not presented");
    end
  endtask

  // Accept the currently presented beat with a one-cycle read_ready pulse.
  task automatic pulse_rready();
    @(posedge clk);
    #1;
    rr_manual = 1'b1;
    @(posedge clk);
    #1;
    rr_manual = 1'b0;
  endtask

  initial begin
    int cnt;
    bus.req_valid   = 1'b0;
    bus.req_rw      = 1'b0;
    bus.req_addr    = '0;
    bus.req_burst   = 1'b0;
    bus.req_size    = '0;
    bus.write_valid = 1'b0;
    bus.write_data  = '0;
    bus.write_strb  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_req_ready", bus.req_ready, 1'b0);
    chk1("rst_write_ready", bus.write_ready, 1'b0);
    chk1("rst_read_valid", bus.read_valid, 1'b0);
    chk("rst_read_data", bus.read_data, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_req_ready", bus.req_ready, 1'b1);
    @(posedge clk);
    #1;

    // Fill the whole memory so every later read has a known expectation.
    do_write('0, 1'b1, MW, 1'b0);

    // Single write then single read.
    rr_auto = 1'b1;
    wd_q.push_back({16{32'hdeadbeef}});
    do_write(32'h40, 1'b0, 0, 1'b0);
    do_read(32'h40, 1'b0, 0);

    // Burst of 4, read back with a 3-cycle stall on beat 2.
    for (int i = 0; i < 4; i++) wd_q.push_back(DW'(i + 1));
    do_write(32'h0, 1'b1, 4, 1'b1);
    rr_auto = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(mem_m[i]);
    send_req(1'b0, 32'h0, 1'b1, 16'd4);
    for (int b = 0; b < 4; b++) begin
      wait_rvalid();
      if (b == 1) begin
        for (int s = 0; s < 3; s++) begin
          chk("stall_hold_data", bus.read_data, DW'(2));
          chk1("stall_hold_valid", bus.read_valid, 1'b1);
          if (s < 2) @(negedge clk);
        end
      end
      pulse_rready();
    end
    @(negedge clk);
    chk1("stall_done_rvalid", bus.read_valid, 1'b0);
    chk1("stall_done_rqready", bus.req_ready, 1'b1);
    chk1("stall_all_beats", exp_q.size() == 0, 1'b1);
    @(posedge clk);
    #1;

    // Byte strobe on word 5.
    rr_auto = 1'b1;
    wd_q.push_back({NB{8'hff}});
    do_write(32'h140, 1'b0, 0, 1'b0);
    wd_q.push_back('0);
    ws_q.push_back(NB'(1));
    do_write(32'h140, 1'b0, 0, 1'b0);
    do_read(32'h140, 1'b0, 0);

    // Wrap from the last word to the first.
    do_write(AW'(1023 * NB), 1'b1, 3, 1'b1);
    do_read(AW'(1023 * NB), 1'b1, 3);

    // Zero-size burst: exactly one beat, even with write_valid held high.
    do_write(AW'(21 * NB), 1'b0, 0, 1'b0);
    send_req(1'b1, AW'(20 * NB), 1'b1, 16'd0);
    bus.write_valid = 1'b1;
    bus.write_data  = rnd_word();
    bus.write_strb  = '1;
    model_write(20, bus.write_data, bus.write_strb);
    cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.write_valid && bus.write_ready) cnt++;
      if (c == 1) begin
        chk1("zero_wready_drop", bus.write_ready, 1'b0);
        chk1("zero_rqready", bus.req_ready, 1'b1);
      end
      @(posedge clk);
      #1;
      bus.write_data = rnd_word();
    end
    bus.write_valid = 1'b0;
    chk("zero_beat_count", DW'(cnt), DW'(1));
    do_read(AW'(20 * NB), 1'b1, 2);

    // Reset in the middle of an 8-beat read.
    do_write('0, 1'b1, 8, 1'b0);
    rr_auto = 1'b0;
    for (int i = 0; i < 8; i++) exp_q.push_back(mem_m[i]);
    send_req(1'b0, '0, 1'b1, 16'd8);
    wait_rvalid();
    pulse_rready();
    wait_rvalid();
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk1("midrst_rvalid", bus.read_valid, 1'b0);
      chk1("midrst_rqready", bus.req_ready, 1'b0);
      chk("midrst_rdata", bus.read_data, '0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk1("midrst_after_rqready", bus.req_ready, 1'b1);
    chk1("midrst_after_rvalid", bus.read_valid, 1'b0);
    @(posedge clk);
    #1;
    rr_auto = 1'b1;
    do_read('0, 1'b0, 0);

    // Randomized traffic over the full address space.
    for (int i = 0; i < 40; i++) begin
      bit            rw    = 1'($urandom());
      bit            burst = 1'($urandom());
      int            size  = $urandom_range(0, 6);
      logic [AW-1:0] addr  = $urandom();
      if (rw) begin
        for (int b = 0; b < beats(burst, size); b++) ws_q.push_back(rnd_word()[NB-1:0]);
        do_write(addr, burst, size, 1'b1);
      end else begin
        do_read(addr, burst, size);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
